// File: rtl/tb_irq_stim_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_stim_if
// Desc     : Interrupt request/acknowledge bundle between stimulus and core.
// Revision : 1.0 - initial release
// ============================================================================
interface tb_irq_stim_if #(
  parameter int ID_W = 5
) ();
  logic            irq_o;
  logic [ID_W-1:0] irq_id_o;
  logic            irq_ack_i;
  logic [ID_W-1:0] irq_id_ack_i;

  modport master (output irq_o, irq_id_o, input irq_ack_i, irq_id_ack_i);
  modport slave  (input irq_o, irq_id_o, output irq_ack_i, irq_id_ack_i);
endinterface
`default_nettype wire

// File: rtl/tb_irq_stim.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_stim
// Desc     : Multi-channel interrupt stimulus generator with a lowest-index
//            arbiter onto a single request line, plus ack error tracking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_stim #(
  parameter int N_IRQ       = 4,
  parameter int ID_W        = 5,
  parameter int ID_BASE     = 16,
  parameter int CNT_W       = 24,
  parameter int SVC_W       = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic [N_IRQ-1:0]       cfg_en,
  input  wire logic [N_IRQ*CNT_W-1:0] cfg_delay,
  input  wire logic [N_IRQ*CNT_W-1:0] cfg_period,
  input  wire logic [N_IRQ*SVC_W-1:0] cfg_limit,
  tb_irq_stim_if.master               irq_bus,
  output logic [N_IRQ-1:0]            pend_o,
  output logic [N_IRQ-1:0]            done_o,
  output logic [N_IRQ*SVC_W-1:0]      svc_cnt_o,
  output logic                        timeout_err_o,
  output logic                        id_err_o
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_PEND = 2'd2,
    CH_DONE = 2'd3
  } ch_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ASSERT = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_e;

  // One-cycle pulse per channel: its presented request got a matching ack.
  logic [N_IRQ-1:0] svc_hit;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SVC_W-1:0] svc_q, svc_d;
    logic [CNT_W-1:0] delay, period;
    logic [SVC_W-1:0] limit, svc_inc;

    assign delay   = cfg_delay[gi*CNT_W +: CNT_W];
    assign period  = cfg_period[gi*CNT_W +: CNT_W];
    assign limit   = cfg_limit[gi*SVC_W +: SVC_W];
    assign svc_inc = (svc_q == '1) ? svc_q : svc_q + SVC_W'(1);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      svc_d   = svc_q;
      if (!cfg_en[gi]) begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        svc_d   = '0;
      end else begin
        case (state_q)
          CH_IDLE: begin
            cnt_d   = delay;
            state_d = CH_WAIT;
          end
          CH_WAIT: begin
            if (cnt_q == '0) state_d = CH_PEND;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
          CH_PEND: begin
            if (svc_hit[gi]) begin
              svc_d = svc_inc;
              if ((limit != '0) && (svc_inc == limit)) begin
                state_d = CH_DONE;
              end else if (period == '0) begin
                state_d = CH_DONE;
              end else begin
                // Minus one so the re-pend lands exactly P cycles after the ack.
                cnt_d   = period - CNT_W'(1);
                state_d = CH_WAIT;
              end
            end
          end
          CH_DONE: state_d = CH_DONE;
          default: state_d = CH_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= CH_IDLE;
        cnt_q   <= '0;
        svc_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        svc_q   <= svc_d;
      end
    end

    assign pend_o[gi]                    = (state_q == CH_PEND);
    assign done_o[gi]                    = (state_q == CH_DONE);
    assign svc_cnt_o[gi*SVC_W +: SVC_W] = svc_q;
  end

  arb_state_e       arb_state_q, arb_state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_err_q, timeout_err_d;
  logic             id_err_q, id_err_d;
  logic [IDX_W-1:0] pick;

  always_comb begin
    pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_o[i]) pick = IDX_W'(i);
    end
  end

  always_comb begin
    arb_state_d   = arb_state_q;
    idx_d         = idx_q;
    irq_id_d      = irq_id_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    id_err_d      = id_err_q;
    svc_hit       = '0;
    case (arb_state_q)
      ARB_IDLE: begin
        if (|pend_o) begin
          idx_d       = pick;
          irq_id_d    = ID_W'(ID_BASE) + ID_W'(pick);
          tmo_d       = '0;
          arb_state_d = ARB_ASSERT;
        end
      end
      ARB_ASSERT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!cfg_en[idx_q]) begin
          arb_state_d = ARB_GAP;
        end else if (irq_bus.irq_ack_i && (irq_bus.irq_id_ack_i == irq_id_q)) begin
          svc_hit[idx_q] = 1'b1;
          arb_state_d    = ARB_GAP;
        end else begin
          if (irq_bus.irq_ack_i) id_err_d = 1'b1;
          if (tmo_q == C_TMO_LAST) begin
            timeout_err_d = 1'b1;
            arb_state_d   = ARB_GAP;
          end
        end
      end
      ARB_GAP: arb_state_d = ARB_IDLE;
      default: arb_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state_q   <= ARB_IDLE;
      idx_q         <= '0;
      irq_id_q      <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      id_err_q      <= 1'b0;
    end else begin
      arb_state_q   <= arb_state_d;
      idx_q         <= idx_d;
      irq_id_q      <= irq_id_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      id_err_q      <= id_err_d;
    end
  end

  // Request is decoded from the state flop so async reset drops it at once.
  assign irq_bus.irq_o    = (arb_state_q == ARB_ASSERT);
  assign irq_bus.irq_id_o = irq_id_q;
  assign timeout_err_o    = timeout_err_q;
  assign id_err_o         = id_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tb_irq_stim.sv
`default_nettype none
// ============================================================================
// Module   : tb_tb_irq_stim
// Desc     : Self-checking bench for tb_irq_stim with a cycle-level event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tb_irq_stim;
  localparam int N       = 4;
  localparam int ID_W    = 5;
  localparam int ID_BASE = 16;
  localparam int CNT_W   = 24;
  localparam int SVC_W   = 8;
  localparam int T       = 16;

  logic               clk        = 1'b0;
  logic               rst_n      = 1'b1;
  logic [N-1:0]       cfg_en     = '0;
  logic [N*CNT_W-1:0] cfg_delay  = '0;
  logic [N*CNT_W-1:0] cfg_period = '0;
  logic [N*SVC_W-1:0] cfg_limit  = '0;
  logic [N-1:0]       pend_o, done_o;
  logic [N*SVC_W-1:0] svc_cnt_o;
  logic               timeout_err_o, id_err_o;

  tb_irq_stim_if #(.ID_W(ID_W)) bus ();

  tb_irq_stim #(
    .N_IRQ(N), .ID_W(ID_W), .ID_BASE(ID_BASE), .CNT_W(CNT_W),
    .SVC_W(SVC_W), .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_delay(cfg_delay),
    .cfg_period(cfg_period), .cfg_limit(cfg_limit), .irq_bus(bus.master),
    .pend_o(pend_o), .done_o(done_o), .svc_cnt_o(svc_cnt_o),
    .timeout_err_o(timeout_err_o), .id_err_o(id_err_o)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  // Model: channels as absolute fire times, arbiter as mode + start cycle.
  bit     m_active [N];
  bit     m_pend   [N];
  bit     m_done   [N];
  longint m_fire   [N];
  int     m_svc    [N];
  int     m_mode;
  int     m_ch;
  longint m_since;
  int     m_id;
  bit     m_terr, m_ierr;

  bit     prev_irq, prev_p0;
  longint p0_rise;
  longint rise_q[$];
  longint fall_q[$];
  int     rid_q[$];

  bit ack_en, bad_first, rnd_mode, spur;
  int core_lat, hi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_fire[i] = 0; m_svc[i] = 0;
    end
    m_mode = 0; m_ch = 0; m_since = 0; m_id = 0; m_terr = 0; m_ierr = 0;
  endfunction

  function automatic void model_step();
    bit     old_pend [N];
    int     served, pick, l;
    longint d, p;
    old_pend = m_pend;
    served   = -1;
    case (m_mode)
      1: begin
        if (!cfg_en[m_ch]) begin
          m_mode = 2;
        end else if (bus.irq_ack_i && int'(bus.irq_id_ack_i) == m_id) begin
          served = m_ch;
          m_mode = 2;
        end else begin
          if (bus.irq_ack_i) m_ierr = 1;
          if (cyc - m_since == T) begin
            m_terr = 1;
            m_mode = 2;
          end
        end
      end
      2: m_mode = 0;
      default: begin
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (old_pend[i]) pick = i;
        if (pick >= 0) begin
          m_mode = 1; m_ch = pick; m_since = cyc; m_id = ID_BASE + pick;
        end
      end
    endcase
    for (int i = 0; i < N; i++) begin
      d = longint'(cfg_delay[i*CNT_W +: CNT_W]);
      p = longint'(cfg_period[i*CNT_W +: CNT_W]);
      l = int'(cfg_limit[i*SVC_W +: SVC_W]);
      if (!cfg_en[i]) begin
        m_active[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_svc[i] = 0;
      end else if (!m_active[i]) begin
        m_active[i] = 1;
        m_fire[i]   = cyc + d + 1;
      end else if (m_done[i]) begin
      end else if (m_pend[i]) begin
        if (served == i) begin
          m_svc[i]  = (m_svc[i] < 255) ? m_svc[i] + 1 : 255;
          m_pend[i] = 0;
          if ((l != 0 && m_svc[i] == l) || p == 0) m_done[i] = 1;
          else                                      m_fire[i] = cyc + p;
        end
      end else if (cyc == m_fire[i]) begin
        m_pend[i] = 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0]       ep, ed;
    logic [N*SVC_W-1:0] es;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_pend[i];
      ed[i] = m_done[i];
      es[i*SVC_W +: SVC_W] = SVC_W'(m_svc[i]);
    end
    chk("irq",      bus.irq_o, (m_mode == 1));
    chk("irq_id",   bus.irq_id_o, m_id);
    chk("pend",     pend_o, ep);
    chk("done",     done_o, ed);
    chk("svc_cnt",  svc_cnt_o, es);
    chk("tmo_err",  timeout_err_o, m_terr);
    chk("id_err",   id_err_o, m_ierr);
  endtask

  task automatic core_drive();
    logic            ack;
    logic [ID_W-1:0] aid;
    ack = 1'b0;
    aid = '0;
    if (bus.irq_o) begin
      if (hi == 0 && rnd_mode) begin
        core_lat  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
        bad_first = ($urandom_range(0, 9) == 0);
      end
      hi++;
      if (ack_en && hi == core_lat) begin
        ack = 1'b1;
        aid = bad_first ? (bus.irq_id_o ^ ID_W'(4)) : bus.irq_id_o;
      end else if (ack_en && bad_first && hi == core_lat + 2) begin
        ack = 1'b1;
        aid = bus.irq_id_o;
      end
    end else begin
      hi = 0;
      if (spur && $urandom_range(0, 7) == 0) begin
        ack = 1'b1;
        aid = ID_W'($urandom);
      end
    end
    bus.irq_ack_i    = ack;
    bus.irq_id_ack_i = aid;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare_all();
    if (bus.irq_o && !prev_irq) begin
      rise_q.push_back(cyc);
      rid_q.push_back(int'(bus.irq_id_o));
    end
    if (!bus.irq_o && prev_irq) fall_q.push_back(cyc);
    if (pend_o[0] && !prev_p0 && p0_rise < 0) p0_rise = cyc;
    prev_irq = bus.irq_o;
    prev_p0  = pend_o[0];
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      core_drive();
      tick();
    end
  endtask

  task automatic set_ch(input int i, input bit en, input int unsigned d,
                        input int unsigned p, input int unsigned l);
    cfg_en[i]                    = en;
    cfg_delay[i*CNT_W +: CNT_W]  = CNT_W'(d);
    cfg_period[i*CNT_W +: CNT_W] = CNT_W'(p);
    cfg_limit[i*SVC_W +: SVC_W]  = SVC_W'(l);
  endtask

  // Reset is asserted between clock edges to exercise its asynchronous path.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_irq",  bus.irq_o, 0);
    chk("rst_id",   bus.irq_id_o, 0);
    chk("rst_pend", pend_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_svc",  svc_cnt_o, 0);
    chk("rst_err",  {timeout_err_o, id_err_o}, 0);
    model_reset();
    cfg_en = '0; cfg_delay = '0; cfg_period = '0; cfg_limit = '0;
    bus.irq_ack_i = 1'b0; bus.irq_id_ack_i = '0;
    ack_en = 1; bad_first = 0; rnd_mode = 0; spur = 0; core_lat = 1; hi = 0;
    prev_irq = 0; prev_p0 = 0; p0_rise = -1;
    rise_q.delete(); fall_q.delete(); rid_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0;
    int     ch;
    bus.irq_ack_i    = 1'b0;
    bus.irq_id_ack_i = '0;

    // One-shot with delay 10 and a 3-cycle ack.
    do_reset();
    core_lat = 3;
    set_ch(0, 1, 10, 0, 0);
    t0 = cyc;
    run(40);
    chk("t1_pend_cyc", p0_rise - t0 - 1, 11);
    chk("t1_irq_cyc",  rise_q[0] - t0 - 1, 12);
    chk("t1_id",       rid_q[0], 16);
    chk("t1_pulses",   rise_q.size(), 1);
    chk("t1_svc",      svc_cnt_o[SVC_W-1:0], 1);
    chk("t1_done",     done_o[0], 1);
    chk("t1_err",      {timeout_err_o, id_err_o}, 0);

    // Periodic with a service limit of 3.
    do_reset();
    core_lat = 1;
    set_ch(0, 1, 5, 20, 3);
    run(120);
    chk("t2_pulses",  rise_q.size(), 3);
    chk("t2_space1",  rise_q[1] - rise_q[0], 22);
    chk("t2_space2",  rise_q[2] - rise_q[1], 22);
    chk("t2_done",    done_o[0], 1);
    chk("t2_svc",     svc_cnt_o[SVC_W-1:0], 3);

    // Simultaneous pends on ch1 and ch3.
    do_reset();
    set_ch(1, 1, 4, 0, 0);
    set_ch(3, 1, 4, 0, 0);
    run(30);
    chk("t3_first_id",  rid_q[0], 17);
    chk("t3_second_id", rid_q[1], 19);
    chk("t3_low_gap",   rise_q[1] - fall_q[0], 2);
    chk("t3_svc1",      svc_cnt_o[1*SVC_W +: SVC_W], 1);
    chk("t3_svc3",      svc_cnt_o[3*SVC_W +: SVC_W], 1);

    // Ack timeout, then re-presentation of the still-pending channel.
    do_reset();
    ack_en = 0;
    set_ch(0, 1, 2, 0, 0);
    run(40);
    chk("t4_high_len",  fall_q[0] - rise_q[0], T);
    chk("t4_tmo_err",   timeout_err_o, 1);
    chk("t4_represent", rise_q[1] - fall_q[0], 2);
    chk("t4_re_id",     rid_q[1], 16);
    ack_en = 1;
    core_lat = 1;
    run(20);
    chk("t4_svc",  svc_cnt_o[SVC_W-1:0], 1);
    chk("t4_done", done_o[0], 1);

    // Wrong ack id first, correct ack two cycles later.
    do_reset();
    core_lat = 2;
    bad_first = 1;
    set_ch(0, 1, 2, 0, 0);
    run(30);
    chk("t5_id_err", id_err_o, 1);
    chk("t5_pulses", rise_q.size(), 1);
    chk("t5_svc",    svc_cnt_o[SVC_W-1:0], 1);
    chk("t5_tmo",    timeout_err_o, 0);

    // Disable while asserted.
    do_reset();
    ack_en = 0;
    set_ch(0, 1, 2, 0, 0);
    run(5);
    chk("t6_irq_hi", bus.irq_o, 1);
    cfg_en[0] = 1'b0;
    run(1);
    chk("t6_irq_drop", bus.irq_o, 0);
    chk("t6_pend",     pend_o[0], 0);
    chk("t6_err",      {timeout_err_o, id_err_o}, 0);
    run(5);

    // Reset while asserted.
    do_reset();
    ack_en = 0;
    set_ch(0, 1, 2, 0, 0);
    run(5);
    chk("t7_irq_hi", bus.irq_o, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rnd_mode = 1;
      spur     = 1;
      for (int i = 0; i < N; i++) begin
        set_ch(i, 1, $urandom_range(0, 30),
               ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40),
               $urandom_range(0, 4));
      end
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 149) == 0) begin
          ch = int'($urandom_range(0, N - 1));
          cfg_en[ch] = ~cfg_en[ch];
        end
        core_drive();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
